counter_dispatcher: RTL and testbench

Scheduler between the customer FIFO and the service counters. Whenever a counter is idle and the FIFO holds a customer, it pops the head entry {number, service time} and loads it into the lowest-index idle counter. Each busy counter then counts down its service time on a slow `tick` enable, frees itself at zero and reports completion. Counter state and a served-customer total are exported to the display/debug logic.

---
 rtl/bank_pkg.sv | 16 +
 rtl/counter_dispatcher_if.sv | 20 ++
 rtl/service_counter.sv | 81 ++++++++
 rtl/counter_dispatcher.sv | 88 ++++++++
 tb/tb_counter_dispatcher.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bank_pkg.sv
// Shared definitions for the bank service-counter slice.
//   NUM_W / TIME_W : default customer-number and service-time widths
//   SERVED_W       : width of the served-customer total
//   ctr_state_e    : per-counter state encoding
package bank_pkg;

  localparam int unsigned NUM_W    = 4;
  localparam int unsigned TIME_W   = 4;
  localparam int unsigned SERVED_W = 8;

  typedef enum logic {
    CTR_IDLE = 1'b0,
    CTR_BUSY = 1'b1
  } ctr_state_e;

endpackage

// File: rtl/counter_dispatcher_if.sv
// Customer FIFO read port.
//   q_empty : FIFO empty flag
//   q_num   : head customer number (combinational from FIFO)
//   q_time  : head service time
//   q_re    : pop strobe from the dispatcher
// master = dispatcher side, slave = FIFO side.
interface counter_dispatcher_if #(
  parameter int unsigned NUM_W  = 4,
  parameter int unsigned TIME_W = 4
);

  logic              q_empty;
  logic [NUM_W-1:0]  q_num;
  logic [TIME_W-1:0] q_time;
  logic              q_re;

  modport master (output q_re, input q_empty, q_num, q_time);
  modport slave  (input q_re, output q_empty, q_num, q_time);

endinterface

// File: rtl/service_counter.sv
// One service counter slot.
//   load     : take num/svc_time this edge (only asserted while idle)
//   num      : customer number to load
//   svc_time : service time to load; 0 is treated as 1
//   tick_en  : qualified service tick (tick & run)
//   busy     : slot is serving a customer
//   num_q    : current / last served customer number
//   rem      : remaining service time
//   done     : one-cycle pulse in the cycle after the finishing tick
module service_counter #(
  parameter int unsigned NUM_W  = 4,
  parameter int unsigned TIME_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [NUM_W-1:0]  num,
  input  logic [TIME_W-1:0] svc_time,
  input  logic              tick_en,
  output logic              busy,
  output logic [NUM_W-1:0]  num_q,
  output logic [TIME_W-1:0] rem,
  output logic              done
);

  import bank_pkg::ctr_state_e;
  import bank_pkg::CTR_IDLE;
  import bank_pkg::CTR_BUSY;

  localparam logic [TIME_W-1:0] ONE = TIME_W'(1);

  ctr_state_e        state_q, state_d;
  logic [NUM_W-1:0]  num_d;
  logic [TIME_W-1:0] rem_d;
  logic              fin;

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    rem_d   = rem;
    fin     = 1'b0;
    case (state_q)
      CTR_IDLE: begin
        if (load) begin
          state_d = CTR_BUSY;
          num_d   = num;
          rem_d   = (svc_time == '0) ? ONE : svc_time;
        end
      end
      CTR_BUSY: begin
        if (tick_en) begin
          if (rem == ONE) begin
            state_d = CTR_IDLE;
            rem_d   = '0;
            fin     = 1'b1;
          end else begin
            rem_d = rem - ONE;
          end
        end
      end
      default: state_d = CTR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CTR_IDLE;
      num_q   <= '0;
      rem     <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      rem     <= rem_d;
      done    <= fin;
    end
  end

  assign busy = (state_q == CTR_BUSY);

endmodule

// File: rtl/counter_dispatcher.sv
// Dispatches FIFO customers to the lowest-index idle service counter and
// tracks completions.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : 1 = dispatch/service enabled, 0 = freeze
//   tick       : one-cycle service-time strobe
//   fifo       : FIFO read port (q_empty/q_num/q_time in, q_re out)
//   busy       : per-counter busy flags
//   cnum, crem : per-counter customer number / remaining time, packed by index
//   done       : per-counter completion pulses
//   served     : total finished customers, wraps
//   all_idle   : FIFO empty and no counter busy
module counter_dispatcher #(
  parameter int unsigned NCTR   = 3,
  parameter int unsigned NUM_W  = bank_pkg::NUM_W,
  parameter int unsigned TIME_W = bank_pkg::TIME_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic                         tick,
  counter_dispatcher_if.master         fifo,
  output logic [NCTR-1:0]              busy,
  output logic [NCTR*NUM_W-1:0]        cnum,
  output logic [NCTR*TIME_W-1:0]       crem,
  output logic [NCTR-1:0]              done,
  output logic [bank_pkg::SERVED_W-1:0] served,
  output logic                         all_idle
);

  import bank_pkg::SERVED_W;

  logic                tick_en;
  logic                q_re;
  logic [NCTR-1:0]     idle;
  logic [NCTR-1:0]     first_idle;
  logic [NCTR-1:0]     load;
  logic [NCTR-1:0]     finish;
  logic [SERVED_W-1:0] fin_cnt;

  assign tick_en = run & tick;
  assign idle    = ~busy;
  assign q_re    = run & ~fifo.q_empty & (|idle);
  assign fifo.q_re = q_re;

  // Isolate the lowest set bit of the idle mask: x & (~x + 1).
  assign first_idle = idle & (~idle + NCTR'(1));
  assign load       = q_re ? first_idle : '0;

  for (genvar g = 0; g < NCTR; g++) begin : g_ctr
    service_counter #(
      .NUM_W  (NUM_W),
      .TIME_W (TIME_W)
    ) u_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[g]),
      .num      (fifo.q_num),
      .svc_time (fifo.q_time),
      .tick_en  (tick_en),
      .busy     (busy[g]),
      .num_q    (cnum[g*NUM_W +: NUM_W]),
      .rem      (crem[g*TIME_W +: TIME_W]),
      .done     (done[g])
    );

    // Same finishing condition the slot uses, so served updates on the
    // edge that raises done and is visible alongside it.
    assign finish[g] = busy[g] & tick_en & (crem[g*TIME_W +: TIME_W] == TIME_W'(1));
  end

  always_comb begin
    fin_cnt = '0;
    for (int unsigned i = 0; i < NCTR; i++) begin
      fin_cnt = fin_cnt + SERVED_W'(finish[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      served <= '0;
    end else begin
      served <= served + fin_cnt;
    end
  end

  assign all_idle = fifo.q_empty & ~(|busy);

endmodule

// File: tb/tb_counter_dispatcher.sv
module tb_counter_dispatcher;

  localparam int NC = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          run;
  logic          tick;
  logic [NC-1:0] busy;
  logic [NC*4-1:0] cnum;
  logic [NC*4-1:0] crem;
  logic [NC-1:0] done;
  logic [7:0]    served;
  logic          all_idle;

  counter_dispatcher_if #(.NUM_W(4), .TIME_W(4)) ifc ();

  counter_dispatcher #(.NCTR(NC), .NUM_W(4), .TIME_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .tick     (tick),
    .fifo     (ifc),
    .busy     (busy),
    .cnum     (cnum),
    .crem     (crem),
    .done     (done),
    .served   (served),
    .all_idle (all_idle)
  );

  always #5 clk = ~clk;

  typedef struct { int num; int tm; } cust_t;
  cust_t fq[$];

  int checks = 0;
  int passed = 0;

  // Reference model: plain per-counter integers
  int m_busy [NC];
  int m_num  [NC];
  int m_rem  [NC];
  int m_done [NC];
  int m_served;
  bit m_qre;
  bit seen_qre;

  function automatic logic [NC-1:0] exp_busy();
    for (int i = 0; i < NC; i++) exp_busy[i] = (m_busy[i] != 0);
  endfunction
  function automatic logic [NC-1:0] exp_done();
    for (int i = 0; i < NC; i++) exp_done[i] = (m_done[i] != 0);
  endfunction
  function automatic logic [NC*4-1:0] exp_cnum();
    for (int i = 0; i < NC; i++) exp_cnum[i*4 +: 4] = 4'(m_num[i]);
  endfunction
  function automatic logic [NC*4-1:0] exp_crem();
    for (int i = 0; i < NC; i++) exp_crem[i*4 +: 4] = 4'(m_rem[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_busy[i] = 0; m_num[i] = 0; m_rem[i] = 0; m_done[i] = 0;
    end
    m_served = 0;
  endtask

  task automatic drive_fifo();
    ifc.q_empty = (fq.size() == 0);
    ifc.q_num   = (fq.size() != 0) ? 4'(fq[0].num) : 4'd0;
    ifc.q_time  = (fq.size() != 0) ? 4'(fq[0].tm)  : 4'd0;
  endtask

  task automatic push(input int n, input int t);
    cust_t c;
    c.num = n; c.tm = t;
    fq.push_back(c);
    drive_fifo();
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input bit tk);
    int tgt;
    bit any_idle;
    tick = tk;
    drive_fifo();
    #1;
    seen_qre = ifc.q_re;
    any_idle = 0;
    tgt = -1;
    for (int i = 0; i < NC; i++) begin
      if (m_busy[i] == 0) begin
        any_idle = 1;
        if (tgt < 0) tgt = i;
      end
    end
    m_qre = run && (fq.size() != 0) && any_idle;
    for (int i = 0; i < NC; i++) m_done[i] = 0;
    if (run && tk) begin
      for (int i = 0; i < NC; i++) begin
        if (m_busy[i] != 0) begin
          if (m_rem[i] == 1) begin
            m_busy[i] = 0; m_rem[i] = 0; m_done[i] = 1;
            m_served = (m_served + 1) % 256;
          end else begin
            m_rem[i] = m_rem[i] - 1;
          end
        end
      end
    end
    if (m_qre) begin
      m_busy[tgt] = 1;
      m_num[tgt]  = fq[0].num;
      m_rem[tgt]  = (fq[0].tm == 0) ? 1 : fq[0].tm;
    end
    @(posedge clk);
    #1;
    if (seen_qre && fq.size() != 0) void'(fq.pop_front());
    drive_fifo();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    fq.delete();
    drive_fifo();
    model_reset();
    tick = 1'b0;
    run  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b1; tick = 1'b0;
    fq.delete(); drive_fifo(); model_reset();
    #1;
    checks++; if (busy !== 3'b000) $display("FAIL reset_busy got=%b exp=000", busy); else passed++;
    checks++; if (cnum !== 12'h000) $display("FAIL reset_cnum got=%h exp=000", cnum); else passed++;
    checks++; if (crem !== 12'h000) $display("FAIL reset_crem got=%h exp=000", crem); else passed++;
    checks++; if (done !== 3'b000) $display("FAIL reset_done got=%b exp=000", done); else passed++;
    checks++; if (served !== 8'd0) $display("FAIL reset_served got=%0d exp=0", served); else passed++;
    checks++; if (ifc.q_re !== 1'b0) $display("FAIL reset_qre got=%b exp=0", ifc.q_re); else passed++;
    checks++; if (all_idle !== 1'b1) $display("FAIL reset_all_idle got=%b exp=1", all_idle); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_empty_idle();
    for (int k = 0; k < 6; k++) begin
      cycle(k[0]);
      checks++; if (seen_qre !== 1'b0) $display("FAIL empty_qre cyc=%0d got=%b exp=0", k, seen_qre); else passed++;
      checks++; if (busy !== 3'b000 || all_idle !== 1'b1)
        $display("FAIL empty_state cyc=%0d busy=%b all_idle=%b exp busy=000 all_idle=1", k, busy, all_idle);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    push(5, 2); push(6, 3); push(7, 1);
    cycle(0);
    checks++; if (seen_qre !== 1'b1) $display("FAIL b2b_qre0 got=%b exp=1", seen_qre); else passed++;
    checks++; if (busy !== 3'b001 || cnum[3:0] !== 4'd5 || crem[3:0] !== 4'd2)
      $display("FAIL b2b_load0 busy=%b cnum=%h crem=%h exp busy=001 n=5 r=2", busy, cnum, crem);
    else passed++;
    cycle(0);
    checks++; if (busy !== 3'b011 || cnum[7:4] !== 4'd6 || crem[7:4] !== 4'd3)
      $display("FAIL b2b_load1 busy=%b cnum=%h crem=%h exp busy=011 n=6 r=3", busy, cnum, crem);
    else passed++;
    cycle(0);
    checks++; if (busy !== 3'b111 || cnum !== 12'h765 || crem !== 12'h132)
      $display("FAIL b2b_load2 busy=%b cnum=%h crem=%h exp 111 765 132", busy, cnum, crem);
    else passed++;
    checks++; if (all_idle !== 1'b0) $display("FAIL b2b_all_idle got=%b exp=0", all_idle); else passed++;
    cycle(1);
    checks++; if (done !== 3'b100 || served !== 8'd1)
      $display("FAIL b2b_tick1 done=%b served=%0d exp 100 1", done, served);
    else passed++;
    cycle(0);
    checks++; if (done !== 3'b000) $display("FAIL b2b_pulse_width done=%b exp=000", done); else passed++;
    cycle(1);
    checks++; if (done !== 3'b001 || served !== 8'd2)
      $display("FAIL b2b_tick2 done=%b served=%0d exp 001 2", done, served);
    else passed++;
    cycle(1);
    checks++; if (done !== 3'b010 || served !== 8'd3 || busy !== 3'b000)
      $display("FAIL b2b_tick3 done=%b served=%0d busy=%b exp 010 3 000", done, served, busy);
    else passed++;
    checks++; if (cnum !== 12'h765) $display("FAIL b2b_cnum_hold got=%h exp=765", cnum); else passed++;
  endtask

  task automatic test_full_block();
    apply_reset();
    push(1, 2); push(2, 3); push(3, 3);
    cycle(0); cycle(0); cycle(0);
    push(8, 4);
    cycle(0);
    checks++; if (seen_qre !== 1'b0) $display("FAIL full_qre_a got=%b exp=0", seen_qre); else passed++;
    cycle(1);
    checks++; if (seen_qre !== 1'b0) $display("FAIL full_qre_b got=%b exp=0", seen_qre); else passed++;
    cycle(1);
    checks++; if (seen_qre !== 1'b0 || done !== 3'b001)
      $display("FAIL full_free qre=%b done=%b exp 0 001", seen_qre, done);
    else passed++;
    cycle(0);
    checks++; if (seen_qre !== 1'b1) $display("FAIL full_qre_c got=%b exp=1", seen_qre); else passed++;
    checks++; if (busy !== 3'b111 || cnum[3:0] !== 4'd8 || crem[3:0] !== 4'd4)
      $display("FAIL full_reload busy=%b cnum=%h crem=%h exp 111 n0=8 r0=4", busy, cnum, crem);
    else passed++;
  endtask

  task automatic test_simul_done();
    apply_reset();
    push(3, 2); push(4, 2);
    cycle(0);
    cycle(1);  // counter 1 loads while counter 0 ticks
    checks++; if (crem[3:0] !== 4'd1 || crem[7:4] !== 4'd2)
      $display("FAIL simul_load_tick crem=%h exp r0=1 r1=2", crem);
    else passed++;
    cycle(1);
    checks++; if (done !== 3'b001) $display("FAIL simul_first done=%b exp=001", done); else passed++;
    push(5, 1);
    cycle(0);
    checks++; if (crem[3:0] !== 4'd1 || crem[7:4] !== 4'd1)
      $display("FAIL simul_setup crem=%h exp r0=1 r1=1", crem);
    else passed++;
    cycle(1);
    checks++; if (done !== 3'b011 || served !== 8'd3)
      $display("FAIL simul_done done=%b served=%0d exp 011 3", done, served);
    else passed++;
  endtask

  task automatic test_zero_time();
    apply_reset();
    push(9, 0);
    cycle(0);
    checks++; if (cnum[3:0] !== 4'd9 || crem[3:0] !== 4'd1)
      $display("FAIL zero_load cnum=%h crem=%h exp n0=9 r0=1", cnum, crem);
    else passed++;
    cycle(1);
    checks++; if (done !== 3'b001 || served !== 8'd1)
      $display("FAIL zero_done done=%b served=%0d exp 001 1", done, served);
    else passed++;
  endtask

  task automatic test_run_freeze();
    apply_reset();
    push(5, 6);
    cycle(0);
    cycle(1);
    push(6, 2);
    run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle(1);
      checks++; if (seen_qre !== 1'b0 || crem !== 12'h005 || busy !== 3'b001 || done !== 3'b000)
        $display("FAIL freeze cyc=%0d qre=%b crem=%h busy=%b done=%b exp 0 005 001 000", k, seen_qre, crem, busy, done);
      else passed++;
    end
    run = 1'b1;
    cycle(0);
    checks++; if (busy !== 3'b011 || cnum[7:4] !== 4'd6)
      $display("FAIL resume_load busy=%b cnum=%h exp 011 n1=6", busy, cnum);
    else passed++;
    for (int k = 0; k < 4; k++) begin
      cycle(1);
      checks++; if (crem[3:0] !== 4'(4 - k))
        $display("FAIL resume_count step=%0d got=%0d exp=%0d", k, crem[3:0], 4 - k);
      else passed++;
    end
    checks++; if (served !== 8'd1) $display("FAIL resume_served got=%0d exp=1", served); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 3'b000 || crem !== 12'h000 || served !== 8'd0 || done !== 3'b000)
      $display("FAIL midreset busy=%b crem=%h served=%0d done=%b exp all zero", busy, crem, served, done);
    else passed++;
    fq.delete(); drive_fifo(); model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      if (fq.size() < 4 && $urandom_range(0, 2) == 0)
        push(int'($urandom_range(0, 15)), int'($urandom_range(0, 5)));
      run = ($urandom_range(0, 9) != 0);
      cycle($urandom_range(0, 2) == 0);
      checks++; if (seen_qre !== m_qre) $display("FAIL rnd_qre cyc=%0d got=%b exp=%b", k, seen_qre, m_qre); else passed++;
      checks++; if (busy !== exp_busy()) $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", k, busy, exp_busy()); else passed++;
      checks++; if (cnum !== exp_cnum()) $display("FAIL rnd_cnum cyc=%0d got=%h exp=%h", k, cnum, exp_cnum()); else passed++;
      checks++; if (crem !== exp_crem()) $display("FAIL rnd_crem cyc=%0d got=%h exp=%h", k, crem, exp_crem()); else passed++;
      checks++; if (done !== exp_done()) $display("FAIL rnd_done cyc=%0d got=%b exp=%b", k, done, exp_done()); else passed++;
      checks++; if (served !== 8'(m_served)) $display("FAIL rnd_served cyc=%0d got=%0d exp=%0d", k, served, m_served); else passed++;
      checks++; if (all_idle !== ((fq.size() == 0) && (exp_busy() == 3'b000)))
        $display("FAIL rnd_all_idle cyc=%0d got=%b", k, all_idle);
      else passed++;
    end
  endtask

  initial begin
    ifc.q_empty = 1'b1;
    ifc.q_num   = '0;
    ifc.q_time  = '0;
    test_reset();
    test_empty_idle();
    test_back_to_back();
    test_full_block();
    test_simul_done();
    test_zero_time();
    test_run_freeze();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
